data_mem_access_unit: RTL and testbench
=======================================

Name: data_mem_access_unit

Overview:
- Initiator side of the data-memory interface: turns CPU load/store requests into word-wide MemRead/MemWrite cycles on the data memory.
- Adds byte/halfword loads with sign or zero extension, sub-word stores via read-modify-write, and misalignment detection.
- Sits between the execute stage and the data memory. Request and response use valid/ready handshakes.

Parameters:
- ADDR_W, 32, byte-address width of req_addr and word-address width of mem_address.
- DATA_W, 32, data width; fixed at 32, lane logic assumes 4 bytes.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset
- req_valid  in  1  request present
- req_ready  out  1  unit can accept a request
- req_write  in  1  1=store, 0=load
- req_size  in  2  00 byte, 01 half, 10 word, 11 illegal
- req_signed  in  1  sign-extend sub-word loads
- req_addr  in  ADDR_W  byte address
- req_wdata  in  DATA_W  store data, right-aligned
- resp_valid  out  1  response present
- resp_ready  in  1  consumer takes response
- resp_rdata  out  DATA_W  load result; 0 for stores and errors
- resp_misaligned  out  1  request rejected as misaligned/illegal
- MemRead  out  1  memory read enable
- MemWrite  out  1  memory write enable
- mem_address  out  ADDR_W  word address = req_addr >> 2
- mem_write_data  out  DATA_W  full word to write
- MemData_in  in  DATA_W  combinational read data from memory

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE.
  - req_ready=1; resp_valid, resp_misaligned, MemRead, MemWrite=0.
  - resp_rdata, mem_address, mem_write_data=0.
  - A reset asserted mid-operation drops MemWrite immediately; the in-flight request is discarded with no response.
- States: IDLE, LOAD, RMW_READ, STORE, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid&&req_ready, latch write, size, signed, addr, wdata.
- Misaligned/illegal means any of: size=11; size=01 with addr[0]=1; size=10 with addr[1:0]!=0.
  - Next state RESP with resp_misaligned=1, resp_rdata=0.
  - No MemRead/MemWrite is ever issued for it.
- Load → LOAD:
  - MemRead=1 for exactly one cycle.
  - MemData_in is captured at the end of that cycle, lane-extracted and extended, then → RESP.
- Word store → STORE.
- Byte/half store:
  - → RMW_READ: MemRead=1 for one cycle, capture the old word.
  - → STORE with the new lanes merged into the old word.
- STORE:
  - MemWrite=1 for exactly one cycle, mem_write_data = full word, then → RESP.
- RESP:
  - resp_valid=1; outputs are held stable until resp_ready=1, then → IDLE.
  - req_ready=0 in every state except IDLE. No request overlap: one outstanding request at a time.
- Lanes are little-endian.
  - Byte lane = addr[1:0]: bits [8*lane+7 : 8*lane].
  - Half lane = addr[1]: bits [16*addr[1]+15 : 16*addr[1]].
  - Extension: req_signed=1 replicates the lane MSB; req_signed=0 zero-fills.
- Latency from the accept cycle T, with resp_ready held at 1:
  - misaligned: resp_valid at T+1
  - load: resp_valid at T+2
  - word store: resp_valid at T+2
  - sub-word store: resp_valid at T+3
- MemRead and MemWrite are never high together.
- mem_address and mem_write_data are 0 whenever both enables are low.
- All memory-side outputs are driven from registers or state only, with no combinational path from req_*.

Decomposition:
- Shared package holds:
  - size encodings SZ_BYTE=2'b00, SZ_HALF=2'b01, SZ_WORD=2'b10;
  - the FSM state encodings;
  - a misalignment-check function.
- One sub-module, lane_align: combinational.
  - Load path: extract/extend.
  - Store path: merge bytes into the old word, given size, addr[1:0], signed.
- FSM and registers stay in the top module.

Test Plan:
- Word store: req_addr=0x8, wdata=0xDEADBEEF, size=10.
  - → MemWrite=1 at T+1, mem_address=2, mem_write_data=0xDEADBEEF; resp_valid at T+2, resp_rdata=0.
- Signed byte load: addr=0xB, after the word store above.
  - → MemRead at T+1, mem_address=2; resp_rdata=0xFFFFFFDE at T+2.
  - Repeat with req_signed=0 → 0x000000DE.
- Byte store: addr=0x9, wdata=0x5A.
  - → RMW_READ at T+1 (MemRead, address 2); MemWrite at T+2 with 0xDEAD5AEF; resp_valid at T+3.
- Misaligned half load: addr=0x3.
  - → resp_valid and resp_misaligned=1 at T+1; MemRead/MemWrite never asserted.
  - Repeat with size=11 at addr=0x0: same response.
- Backpressure: hold resp_ready=0 for 3 cycles on a load.
  - → resp_valid and resp_rdata stable; req_ready=0 throughout.
  - A new req_valid during the stall is not accepted until the cycle after the handshake.
- Reset: assert reset=0 during the STORE cycle of a sub-word store.
  - → MemWrite falls without waiting for a clock edge; after release, state=IDLE, req_ready=1, no resp_valid.

Source files
------------

// File: rtl/data_mem_access_unit_pkg.sv
// rtl/data_mem_access_unit_pkg.sv - shared encodings and alignment check for the data memory access unit
package data_mem_access_unit_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_LOAD     = 3'd1,
        ST_RMW_READ = 3'd2,
        ST_STORE    = 3'd3,
        ST_RESP     = 3'd4
    } state_t;

    // size 2'b11 is reserved and always rejected
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
        logic bad;
        case (size)
            SZ_BYTE: bad = 1'b0;
            SZ_HALF: bad = addr_lo[0];
            SZ_WORD: bad = (addr_lo != 2'b00);
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/data_mem_access_unit_lane_align.sv
// rtl/data_mem_access_unit_lane_align.sv - little-endian lane extract/extend for loads and lane merge for stores
module data_mem_access_unit_lane_align
    import data_mem_access_unit_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [1:0]        i_size,
    input  logic [1:0]        i_addr_lo,
    input  logic              i_signed,
    input  logic [DATA_W-1:0] i_rdata,
    input  logic [DATA_W-1:0] i_wdata,
    output logic [DATA_W-1:0] o_load_data,
    output logic [DATA_W-1:0] o_merged
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_byte = 8'h00;
        case (i_addr_lo)
            2'd0: w_byte = i_rdata[7:0];
            2'd1: w_byte = i_rdata[15:8];
            2'd2: w_byte = i_rdata[23:16];
            default: w_byte = i_rdata[31:24];
        endcase
        w_half = i_addr_lo[1] ? i_rdata[31:16] : i_rdata[15:0];

        o_load_data = i_rdata;
        case (i_size)
            SZ_BYTE: o_load_data = {{24{i_signed & w_byte[7]}}, w_byte};
            SZ_HALF: o_load_data = {{16{i_signed & w_half[15]}}, w_half};
            default: o_load_data = i_rdata;
        endcase
    end

    // i_rdata holds the old word here; only the addressed lanes are replaced
    always_comb begin
        o_merged = i_rdata;
        case (i_size)
            SZ_BYTE: begin
                case (i_addr_lo)
                    2'd0: o_merged[7:0]   = i_wdata[7:0];
                    2'd1: o_merged[15:8]  = i_wdata[7:0];
                    2'd2: o_merged[23:16] = i_wdata[7:0];
                    default: o_merged[31:24] = i_wdata[7:0];
                endcase
            end
            SZ_HALF: begin
                if (i_addr_lo[1]) begin
                    o_merged[31:16] = i_wdata[15:0];
                end else begin
                    o_merged[15:0] = i_wdata[15:0];
                end
            end
            default: o_merged = i_wdata;
        endcase
    end

endmodule

// File: rtl/data_mem_access_unit.sv
// rtl/data_mem_access_unit.sv - load/store initiator with sub-word read-modify-write and misalignment rejection
module data_mem_access_unit
    import data_mem_access_unit_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [1:0]        req_size,
    input  logic              req_signed,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_misaligned,
    output logic              MemRead,
    output logic              MemWrite,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_write_data,
    input  logic [DATA_W-1:0] MemData_in
);

    state_t            r_state;
    state_t            w_next_state;
    logic [1:0]        r_size;
    logic              r_signed;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_rdata;
    logic              r_misaligned;
    logic              w_accept;
    logic              w_req_bad;
    logic [DATA_W-1:0] w_load_data;
    logic [DATA_W-1:0] w_merged;

    assign w_accept  = req_valid && (r_state == ST_IDLE);
    assign w_req_bad = is_misaligned(req_size, req_addr[1:0]);

    data_mem_access_unit_lane_align #(
        .DATA_W (DATA_W)
    ) u_lane_align (
        .i_size      (r_size),
        .i_addr_lo   (r_addr[1:0]),
        .i_signed    (r_signed),
        .i_rdata     (MemData_in),
        .i_wdata     (r_wdata),
        .o_load_data (w_load_data),
        .o_merged    (w_merged)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state    = r_state;
        req_ready       = 1'b0;
        resp_valid      = 1'b0;
        resp_rdata      = '0;
        resp_misaligned = 1'b0;
        MemRead         = 1'b0;
        MemWrite        = 1'b0;
        mem_address     = '0;
        mem_write_data  = '0;
        case (r_state)
            ST_IDLE: begin
                req_ready = 1'b1;
                if (w_accept) begin
                    if (w_req_bad) begin
                        w_next_state = ST_RESP;
                    end else if (!req_write) begin
                        w_next_state = ST_LOAD;
                    end else if (req_size == SZ_WORD) begin
                        w_next_state = ST_STORE;
                    end else begin
                        w_next_state = ST_RMW_READ;
                    end
                end
            end
            ST_LOAD: begin
                MemRead      = 1'b1;
                mem_address  = {2'b00, r_addr[ADDR_W-1:2]};
                w_next_state = ST_RESP;
            end
            ST_RMW_READ: begin
                MemRead      = 1'b1;
                mem_address  = {2'b00, r_addr[ADDR_W-1:2]};
                w_next_state = ST_STORE;
            end
            ST_STORE: begin
                MemWrite       = 1'b1;
                mem_address    = {2'b00, r_addr[ADDR_W-1:2]};
                mem_write_data = r_wdata;
                w_next_state   = ST_RESP;
            end
            ST_RESP: begin
                resp_valid      = 1'b1;
                resp_rdata      = r_rdata;
                resp_misaligned = r_misaligned;
                if (resp_ready) begin
                    w_next_state = ST_IDLE;
                end
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    // r_wdata doubles as the write-back word: right-aligned store data until RMW_READ merges it
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_size       <= SZ_BYTE;
            r_signed     <= 1'b0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_rdata      <= '0;
            r_misaligned <= 1'b0;
        end else begin
            if (w_accept) begin
                r_size       <= req_size;
                r_signed     <= req_signed;
                r_addr       <= req_addr;
                r_wdata      <= req_wdata;
                r_rdata      <= '0;
                r_misaligned <= w_req_bad;
            end
            if (r_state == ST_LOAD) begin
                r_rdata <= w_load_data;
            end
            if (r_state == ST_RMW_READ) begin
                r_wdata <= w_merged;
            end
        end
    end

endmodule

// File: tb/tb_data_mem_access_unit.sv
// tb/tb_data_mem_access_unit.sv - directed table-driven bench for data_mem_access_unit
module tb_data_mem_access_unit;

    typedef struct packed {
        logic        write;
        logic [1:0]  size;
        logic        sgn;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_mis;
        logic [3:0]  exp_lat;
        logic [3:0]  exp_reads;
        logic [3:0]  exp_writes;
        logic [31:0] exp_wword;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic        req_signed = 1'b0;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] req_wdata = 32'h0;
    logic        resp_valid;
    logic        resp_ready = 1'b1;
    logic [31:0] resp_rdata;
    logic        resp_misaligned;
    logic        MemRead;
    logic        MemWrite;
    logic [31:0] mem_address;
    logic [31:0] mem_write_data;
    logic [31:0] MemData_in;

    logic        mem_clr = 1'b1;
    logic [31:0] mem [0:15];
    int          n_pass = 0;
    int          n_total = 0;
    vec_t        vecs [16];

    always #5 clk = ~clk;

    data_mem_access_unit #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk             (clk),
        .reset           (reset),
        .req_valid       (req_valid),
        .req_ready       (req_ready),
        .req_write       (req_write),
        .req_size        (req_size),
        .req_signed      (req_signed),
        .req_addr        (req_addr),
        .req_wdata       (req_wdata),
        .resp_valid      (resp_valid),
        .resp_ready      (resp_ready),
        .resp_rdata      (resp_rdata),
        .resp_misaligned (resp_misaligned),
        .MemRead         (MemRead),
        .MemWrite        (MemWrite),
        .mem_address     (mem_address),
        .mem_write_data  (mem_write_data),
        .MemData_in      (MemData_in)
    );

    assign MemData_in = mem[mem_address[3:0]];

    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < 16; i++) mem[i] <= 32'h0;
        end else if (MemWrite) begin
            mem[mem_address[3:0]] <= mem_write_data;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        int lat;
        int reads;
        int writes;
        lat = 0; reads = 0; writes = 0;
        @(negedge clk);
        check($sformatf("v%0d req_ready", idx), {31'b0, req_ready}, 32'd1);
        req_valid = 1'b1; req_write = v.write; req_size = v.size; req_signed = v.sgn;
        req_addr = v.addr; req_wdata = v.wdata;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        for (int c = 1; c <= 10; c++) begin
            lat = c;
            check($sformatf("v%0d rd_wr_excl", idx), {31'b0, MemRead & MemWrite}, 32'd0);
            if (MemRead) begin
                reads++;
                check($sformatf("v%0d rd_addr", idx), mem_address, v.addr >> 2);
            end
            if (MemWrite) begin
                writes++;
                check($sformatf("v%0d wr_addr", idx), mem_address, v.addr >> 2);
                check($sformatf("v%0d wr_data", idx), mem_write_data, v.exp_wword);
            end
            if (!MemRead && !MemWrite) begin
                check($sformatf("v%0d idle_bus", idx), mem_address | mem_write_data, 32'd0);
            end
            if (resp_valid) break;
            @(negedge clk);
        end
        check($sformatf("v%0d latency", idx), lat, {28'b0, v.exp_lat});
        check($sformatf("v%0d rdata", idx), resp_rdata, v.exp_rdata);
        check($sformatf("v%0d misaligned", idx), {31'b0, resp_misaligned}, {31'b0, v.exp_mis});
        check($sformatf("v%0d reads", idx), reads, {28'b0, v.exp_reads});
        check($sformatf("v%0d writes", idx), writes, {28'b0, v.exp_writes});
    endtask

    initial begin
        //           wr    size  sgn  addr   wdata          rdata          mis lat rd wr wword
        vecs[0]  = '{1'b1, 2'b10, 1'b0, 32'h8, 32'hDEADBEEF, 32'h00000000, 1'b0, 4'd2, 4'd0, 4'd1, 32'hDEADBEEF};
        vecs[1]  = '{1'b0, 2'b00, 1'b1, 32'hB, 32'h0,        32'hFFFFFFDE, 1'b0, 4'd2, 4'd1, 4'd0, 32'h0};
        vecs[2]  = '{1'b0, 2'b00, 1'b0, 32'hB, 32'h0,        32'h000000DE, 1'b0, 4'd2, 4'd1, 4'd0, 32'h0};
        vecs[3]  = '{1'b1, 2'b00, 1'b0, 32'h9, 32'h0000005A, 32'h00000000, 1'b0, 4'd3, 4'd1, 4'd1, 32'hDEAD5AEF};
        vecs[4]  = '{1'b0, 2'b01, 1'b1, 32'hA, 32'h0,        32'hFFFFDEAD, 1'b0, 4'd2, 4'd1, 4'd0, 32'h0};
        vecs[5]  = '{1'b0, 2'b01, 1'b0, 32'h8, 32'h0,        32'h00005AEF, 1'b0, 4'd2, 4'd1, 4'd0, 32'h0};
        vecs[6]  = '{1'b0, 2'b10, 1'b0, 32'h8, 32'h0,        32'hDEAD5AEF, 1'b0, 4'd2, 4'd1, 4'd0, 32'h0};
        vecs[7]  = '{1'b0, 2'b01, 1'b0, 32'h3, 32'h0,        32'h00000000, 1'b1, 4'd1, 4'd0, 4'd0, 32'h0};
        vecs[8]  = '{1'b0, 2'b11, 1'b0, 32'h0, 32'h0,        32'h00000000, 1'b1, 4'd1, 4'd0, 4'd0, 32'h0};
        vecs[9]  = '{1'b0, 2'b10, 1'b0, 32'hA, 32'h0,        32'h00000000, 1'b1, 4'd1, 4'd0, 4'd0, 32'h0};
        vecs[10] = '{1'b1, 2'b01, 1'b0, 32'h6, 32'h1234ABCD, 32'h00000000, 1'b0, 4'd3, 4'd1, 4'd1, 32'hABCD0000};
        vecs[11] = '{1'b0, 2'b00, 1'b1, 32'h7, 32'h0,        32'hFFFFFFAB, 1'b0, 4'd2, 4'd1, 4'd0, 32'h0};
        vecs[12] = '{1'b1, 2'b01, 1'b0, 32'h5, 32'hFFFFFFFF, 32'h00000000, 1'b1, 4'd1, 4'd0, 4'd0, 32'h0};
        vecs[13] = '{1'b0, 2'b10, 1'b1, 32'h4, 32'h0,        32'hABCD0000, 1'b0, 4'd2, 4'd1, 4'd0, 32'h0};
        vecs[14] = '{1'b1, 2'b00, 1'b0, 32'h0, 32'h0000007F, 32'h00000000, 1'b0, 4'd3, 4'd1, 4'd1, 32'h0000007F};
        vecs[15] = '{1'b0, 2'b00, 1'b1, 32'h0, 32'h0,        32'h0000007F, 1'b0, 4'd2, 4'd1, 4'd0, 32'h0};

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst req_ready", {31'b0, req_ready}, 32'd1);
        check("rst resp_valid", {31'b0, resp_valid}, 32'd0);
        check("rst resp_mis", {31'b0, resp_misaligned}, 32'd0);
        check("rst mem_en", {30'b0, MemRead, MemWrite}, 32'd0);
        check("rst mem_address", mem_address, 32'd0);
        check("rst mem_wdata", mem_write_data, 32'd0);
        check("rst resp_rdata", resp_rdata, 32'd0);
        reset = 1'b1;
        mem_clr = 1'b0;

        for (int i = 0; i < 16; i++) run_vec(i, vecs[i]);

        // backpressure: response held for 3 stalled cycles while a new request waits
        @(negedge clk);
        resp_ready = 1'b0;
        req_valid = 1'b1; req_write = 1'b0; req_size = 2'b10; req_signed = 1'b0; req_addr = 32'h8;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        req_valid = 1'b1; req_addr = 32'h4;
        for (int i = 0; i < 3; i++) begin
            check("bp resp_valid", {31'b0, resp_valid}, 32'd1);
            check("bp rdata", resp_rdata, 32'hDEAD5AEF);
            check("bp req_ready", {31'b0, req_ready}, 32'd0);
            check("bp no_read", {31'b0, MemRead}, 32'd0);
            @(negedge clk);
        end
        resp_ready = 1'b1;
        @(negedge clk);
        check("bp post_hs resp_valid", {31'b0, resp_valid}, 32'd0);
        check("bp post_hs req_ready", {31'b0, req_ready}, 32'd1);
        check("bp post_hs no_read", {31'b0, MemRead}, 32'd0);
        @(negedge clk);
        req_valid = 1'b0;
        check("bp next MemRead", {31'b0, MemRead}, 32'd1);
        check("bp next addr", mem_address, 32'd1);
        @(negedge clk);
        check("bp next resp", {31'b0, resp_valid}, 32'd1);
        check("bp next rdata", resp_rdata, 32'hABCD0000);

        // reset during the STORE cycle of a byte store
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b1; req_size = 2'b00; req_addr = 32'h4; req_wdata = 32'h11;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        check("rst_mid rmw read", {31'b0, MemRead}, 32'd1);
        @(negedge clk);
        check("rst_mid store", {31'b0, MemWrite}, 32'd1);
        #1 reset = 1'b0;
        #1;
        check("rst_mid MemWrite drop", {31'b0, MemWrite}, 32'd0);
        check("rst_mid addr", mem_address, 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rst_mid req_ready", {31'b0, req_ready}, 32'd1);
            check("rst_mid resp_valid", {31'b0, resp_valid}, 32'd0);
        end
        run_vec(16, vecs[13]);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running, expected finished");
        $fatal(1, "timeout");
    end

endmodule
